// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int SKID_DEPTH     = 2;

   typedef logic [1:0] occ_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order queue; entry 0 is always the head presented downstream.
module skid_buf2
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   input  logic                  i_flush,
   output logic [DATA_WIDTH-1:0] o_head,
   output occ_t                  o_occ
);

   logic [DATA_WIDTH-1:0] r_mem0;
   logic [DATA_WIDTH-1:0] r_mem1;
   occ_t                  r_occ;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_occ  <= '0;
         r_mem0 <= '0;
         r_mem1 <= '0;
      end else if (i_flush) begin
         r_occ <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_mem0 <= i_data;
               else               r_mem1 <= i_data;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_mem0 <= r_mem1;
               r_occ  <= r_occ - 2'd1;
            end
            // Simultaneous push/pop: count holds, captured word lands behind whatever remains.
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_mem0 <= i_data;
               end else begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_head = r_mem0;
   assign o_occ  = r_occ;

   // Issue logic never lets a capture arrive while both entries are full.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_)
      !(i_push && !i_flush && !i_pop && r_occ == occ_t'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a registered-output FIFO read port into a valid/ready stream,
// issuing reads only when the buffer is guaranteed room for the returning word.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output occ_t                  occupancy
);

   logic       r_inflight;
   logic       w_pop;
   logic       w_push;
   logic [2:0] w_sum;
   occ_t       w_occ;

   assign w_pop  = m_valid & m_ready;
   // pop implies occ >= 1, so the 3-bit difference cannot wrap
   assign w_sum  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign fifo_rd_en = rst_ & ~flush & ~fifo_empty & (w_sum < 3'(SKID_DEPTH));
   assign w_push = r_inflight & ~flush;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) r_inflight <= 1'b0;
      else       r_inflight <= fifo_rd_en;
   end

   skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk     (clk),
      .rst_    (rst_),
      .i_push  (w_push),
      .i_data  (fifo_dout),
      .i_pop   (w_pop),
      .i_flush (flush),
      .o_head  (m_data),
      .o_occ   (w_occ)
   );

   assign m_valid   = (w_occ != 2'd0);
   assign occupancy = w_occ;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO in front, beat logger behind,
// scenario tasks compare delivered beats against the loaded word order.
module tb_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst_;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_rd_en;
   logic       flush;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [1:0] occupancy;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_       (rst_),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .occupancy  (occupancy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // loader mailbox: stimulus writes ld_mem/ld_wp, FIFO model consumes
   logic [7:0] ld_mem [256];
   int         ld_wp = 0;

   // synchronous FIFO model: reads iff rd_en & !empty, registered dout and empty
   logic [7:0] fq[$];
   int         ld_rp   = 0;
   int         ovr_cnt = 0;
   int         rd_n    = 0;
   initial fifo_empty = 1'b1;
   initial fifo_dout  = 8'h00;
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         rd_n++;
         if (fq.size() == 0) ovr_cnt++;
         else fifo_dout <= fq.pop_front();
      end
      while (ld_rp != ld_wp) begin
         fq.push_back(ld_mem[ld_rp]);
         ld_rp++;
      end
      fifo_empty <= (fq.size() == 0);
   end

   // beat logger
   logic [7:0] got_mem [512];
   int         got_cyc [512];
   int         got_n = 0;
   int         cyc   = 0;
   always @(posedge clk) begin
      cyc++;
      if (rst_ && m_valid && m_ready) begin
         got_mem[got_n] = m_data;
         got_cyc[got_n] = cyc;
         got_n++;
      end
   end

   task automatic load(input logic [7:0] d);
      ld_mem[ld_wp] = d;
      ld_wp++;
   endtask

   task automatic wait_beats(input int base, input int n, input int budget, input string tag);
      int k = 0;
      while ((got_n - base) < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if ((got_n - base) != n) begin
         n_fail++;
         $display("FAIL %s_beats: got %0d beats, want %0d", tag, got_n - base, n);
      end
   endtask

   task automatic test_reset;
      rst_ = 1'b0; flush = 1'b0; m_ready = 1'b0;
      load(8'hA5);
      repeat (3) @(negedge clk);
      #1;
      n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
      n_chk++; if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: got %b want 0", m_valid); end
      n_chk++; if (occupancy !== 2'd0)  begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
      n_chk++; if (m_data !== 8'h00)    begin n_fail++; $display("FAIL rst_data: got %h want 00", m_data); end
   endtask

   task automatic test_single;
      int r0;
      @(negedge clk);
      rst_ = 1'b1; m_ready = 1'b1; r0 = rd_n;
      #1;
      n_chk++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_t0: got %b want 1", fifo_rd_en); end
      @(negedge clk); #1;
      n_chk++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_t1: rd_en=%b valid=%b want 0/0", fifo_rd_en, m_valid); end
      @(negedge clk); #1;
      n_chk++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
         n_fail++; $display("FAIL single_t2: valid=%b data=%h want 1/a5", m_valid, m_data); end
      @(negedge clk); #1;
      n_chk++; if (m_valid !== 1'b0 || (rd_n - r0) != 1) begin
         n_fail++; $display("FAIL single_t3: valid=%b reads=%0d want 0/1", m_valid, rd_n - r0); end
   endtask

   task automatic test_stream;
      int g0, r0;
      bit ok;
      @(negedge clk);
      m_ready = 1'b1; g0 = got_n; r0 = rd_n;
      for (int i = 0; i < 16; i++) load(8'(i));
      wait_beats(g0, 16, 80, "stream");
      repeat (3) @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < 16 && i < got_n - g0; i++)
         if (got_mem[g0+i] !== 8'(i)) ok = 1'b0;
      n_chk++; if (!ok) begin n_fail++; $display("FAIL stream_data: first beat %h want 00..0f in order", got_mem[g0]); end
      n_chk++; if (got_cyc[g0+15] - got_cyc[g0] != 15) begin
         n_fail++; $display("FAIL stream_gaps: span %0d cycles want 15", got_cyc[g0+15] - got_cyc[g0]); end
      n_chk++; if (rd_n - r0 != 16) begin n_fail++; $display("FAIL stream_reads: got %0d want 16", rd_n - r0); end
   endtask

   task automatic test_backpressure;
      int g0, r0;
      @(negedge clk);
      m_ready = 1'b0; g0 = got_n; r0 = rd_n;
      for (int i = 0; i < 4; i++) load(8'h10 + 8'(i));
      repeat (8) @(negedge clk);
      #1;
      n_chk++; if (rd_n - r0 != 2) begin n_fail++; $display("FAIL bp_reads: got %0d want 2", rd_n - r0); end
      n_chk++; if (occupancy !== 2'd2 || m_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_occ: occ=%0d valid=%b want 2/1", occupancy, m_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_chk++; if (m_data !== 8'h10 || m_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: data=%h valid=%b want 10/1", m_data, m_valid); end
      end
      m_ready = 1'b1;
      wait_beats(g0, 4, 30, "bp");
      repeat (3) @(negedge clk);
      n_chk++; if (got_n - g0 != 4) begin n_fail++; $display("FAIL bp_dup: got %0d beats want 4", got_n - g0); end
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (got_mem[g0+i] !== 8'h10 + 8'(i)) begin
            n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, got_mem[g0+i], 8'h10 + 8'(i)); end
      end
   endtask

   task automatic test_flush;
      int g0;
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) load(8'h20 + 8'(i));
      repeat (8) @(negedge clk); #1;
      n_chk++; if (occupancy !== 2'd2 || m_data !== 8'h20) begin
         n_fail++; $display("FAIL fl_pre: occ=%0d data=%h want 2/20", occupancy, m_data); end
      @(negedge clk); flush = 1'b1; #1;
      n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL fl_rd_en: got %b want 0", fifo_rd_en); end
      @(negedge clk); flush = 1'b0; #1;
      n_chk++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++; $display("FAIL fl_clear: valid=%b occ=%0d want 0/0", m_valid, occupancy); end
      repeat (6) @(negedge clk); #1;
      n_chk++; if (occupancy !== 2'd2 || m_data !== 8'h22) begin
         n_fail++; $display("FAIL fl_resume: occ=%0d data=%h want 2/22", occupancy, m_data); end
      // one pop issues a read, leaving one buffered word plus one in flight
      @(negedge clk); m_ready = 1'b1; g0 = got_n;
      @(negedge clk); m_ready = 1'b0; flush = 1'b1; #1;
      n_chk++; if (occupancy !== 2'd1 || m_data !== 8'h23 || fifo_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL fl2_pre: occ=%0d data=%h rd_en=%b want 1/23/0", occupancy, m_data, fifo_rd_en); end
      @(negedge clk); flush = 1'b0; #1;
      n_chk++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++; $display("FAIL fl2_clear: valid=%b occ=%0d want 0/0", m_valid, occupancy); end
      m_ready = 1'b1;
      wait_beats(g0, 2, 30, "fl");
      repeat (4) @(negedge clk);
      n_chk++; if (got_n - g0 != 2 || got_mem[g0] !== 8'h22 || got_mem[g0+1] !== 8'h25) begin
         n_fail++; $display("FAIL fl_beats: n=%0d b0=%h b1=%h want 2/22/25", got_n - g0, got_mem[g0], got_mem[g0+1]); end
   endtask

   task automatic test_async_reset;
      int r0, nread, g1;
      bit ok;
      @(negedge clk);
      m_ready = 1'b1; r0 = rd_n;
      for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
      repeat (5) @(negedge clk); #1;
      n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL ar_steady: occ=%0d want 1", occupancy); end
      #1;
      rst_ = 1'b0;
      nread = rd_n - r0;
      #1;
      n_chk++; if (m_valid !== 1'b0 || occupancy !== 2'd0 || fifo_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL ar_immediate: valid=%b occ=%0d rd_en=%b want 0/0/0", m_valid, occupancy, fifo_rd_en); end
      @(negedge clk);
      @(negedge clk); rst_ = 1'b1; g1 = got_n;
      wait_beats(g1, 8 - nread, 40, "ar");
      repeat (3) @(negedge clk);
      ok = (got_n - g1 == 8 - nread);
      for (int i = 0; i < 8 - nread && i < got_n - g1; i++)
         if (got_mem[g1+i] !== 8'h30 + 8'(nread + i)) ok = 1'b0;
      n_chk++; if (!ok) begin
         n_fail++; $display("FAIL ar_resume: first beat %h want %h", got_mem[g1], 8'h30 + 8'(nread)); end
   endtask

   task automatic test_random;
      logic [7:0] exp_q[$];
      int   g0, loaded, k;
      logic pv, pr;
      logic [7:0] pd;
      bit   ok;
      @(negedge clk);
      g0 = got_n; loaded = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
      k = 0;
      while ((loaded < 40 || got_n - g0 < 40) && k < 600) begin
         @(negedge clk);
         if (pv && !pr) begin
            n_chk++; if (m_valid !== 1'b1 || m_data !== pd) begin
               n_fail++; $display("FAIL rnd_hold: valid=%b data=%h want 1/%h", m_valid, m_data, pd); end
         end
         n_chk++; if (occupancy > 2'd2 || m_valid !== (occupancy != 2'd0)) begin
            n_fail++; $display("FAIL rnd_occ: occ=%0d valid=%b", occupancy, m_valid); end
         m_ready = ($urandom_range(0, 2) != 0);
         if (loaded < 40 && $urandom_range(0, 1) == 1) begin
            logic [7:0] d;
            d = 8'($urandom);
            load(d); exp_q.push_back(d); loaded++;
         end
         #1;
         pv = m_valid; pr = m_ready; pd = m_data;
         k++;
      end
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      ok = (got_n - g0 == 40);
      for (int i = 0; i < 40 && i < got_n - g0; i++)
         if (got_mem[g0+i] !== exp_q[i]) ok = 1'b0;
      n_chk++; if (!ok) begin
         n_fail++; $display("FAIL rnd_seq: got %0d beats want 40 in load order", got_n - g0); end
      n_chk++; if (ovr_cnt != 0) begin n_fail++; $display("FAIL overread: got %0d want 0", ovr_cnt); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_stream;
      test_backpressure;
      test_flush;
      test_async_reset;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
